// File: rtl/bfm_apb_pkg.sv
// Shared definitions for the APB bus-functional-model bridge: FSM states,
// slot field width and the timeout counter sizing helper.
package bfm_apb_pkg;

  localparam int SLOT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Counter must hold values up to TIMEOUT; a zero-length counter is not legal.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bfm_apb_slot_decode.sv
// Combinational slot decoder: one-hot slave select from the 4-bit slot field,
// plus a flag for slots that have no slave behind them.
module bfm_apb_slot_decode
  import bfm_apb_pkg::*;
#(
  parameter int NSLV = 16
) (
  input  logic [SLOT_W-1:0] slot_i,
  input  logic              active_i,
  output logic [NSLV-1:0]   sel_o,
  output logic              out_of_range_o
);

  assign out_of_range_o = (32'(slot_i) >= NSLV);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel_o = '0;
    for (int i = 0; i < NSLV; i++) begin
      sel_o[i] = active_i && (slot_i == SLOT_W'(i));
    end
  end

endmodule

// File: rtl/bfm_apb2apb_bridge.sv
// Single-clock APB-to-APB bridge: replays one master-side transfer as a full
// SETUP/ACCESS sequence on a decoded slave slot, with select and timeout errors.
module bfm_apb2apb_bridge
  import bfm_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NSLV    = 16,
  parameter int SEL_LSB = 24,
  parameter int TIMEOUT = 256
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL_PM,
  input  logic [ADDR_W-1:0] PADDR_PM,
  input  logic              PWRITE_PM,
  input  logic              PENABLE_PM,
  input  logic [DATA_W-1:0] PWDATA_PM,
  output logic [DATA_W-1:0] PRDATA_PM,
  output logic              PREADY_PM,
  output logic              PSLVERR_PM,
  output logic [NSLV-1:0]   PSEL_SC,
  output logic [ADDR_W-1:0] PADDR_SC,
  output logic              PWRITE_SC,
  output logic              PENABLE_SC,
  output logic [DATA_W-1:0] PWDATA_SC,
  input  logic [DATA_W-1:0] PRDATA_SC,
  input  logic              PREADY_SC,
  input  logic              PSLVERR_SC
);

  localparam int                 CNT_W   = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]   TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NSLV-1:0]     psel_sc_q, psel_sc_d;
  logic [ADDR_W-1:0]   paddr_sc_q, paddr_sc_d;
  logic                pwrite_sc_q, pwrite_sc_d;
  logic                penable_sc_q, penable_sc_d;
  logic [DATA_W-1:0]   pwdata_sc_q, pwdata_sc_d;
  logic [DATA_W-1:0]   prdata_pm_q, prdata_pm_d;
  logic                pready_pm_q, pready_pm_d;
  logic                pslverr_pm_q, pslverr_pm_d;

  logic                req;
  logic [NSLV-1:0]     dec_sel;
  logic                dec_oor;

  assign req = (state_q == IDLE) && PSEL_PM && PENABLE_PM && !pready_pm_q;

  bfm_apb_slot_decode #(.NSLV(NSLV)) u_decode (
    .slot_i         (PADDR_PM[SEL_LSB +: SLOT_W]),
    .active_i       (req),
    .sel_o          (dec_sel),
    .out_of_range_o (dec_oor)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    psel_sc_d    = psel_sc_q;
    paddr_sc_d   = paddr_sc_q;
    pwrite_sc_d  = pwrite_sc_q;
    penable_sc_d = penable_sc_q;
    pwdata_sc_d  = pwdata_sc_q;
    prdata_pm_d  = prdata_pm_q;
    pready_pm_d  = 1'b0;
    pslverr_pm_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          if (dec_oor) begin
            state_d      = RESP;
            pready_pm_d  = 1'b1;
            pslverr_pm_d = 1'b1;
            prdata_pm_d  = '0;
          end else begin
            state_d     = SETUP;
            psel_sc_d   = dec_sel;
            paddr_sc_d  = PADDR_PM;
            pwrite_sc_d = PWRITE_PM;
            pwdata_sc_d = PWDATA_PM;
          end
        end
      end
      SETUP: begin
        state_d      = ACCESS;
        penable_sc_d = 1'b1;
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready is checked first so it wins over a timeout on the same edge.
        if (PREADY_SC || (TIMEOUT != 0 && cnt_q == TO_LAST)) begin
          state_d      = RESP;
          pready_pm_d  = 1'b1;
          pslverr_pm_d = PREADY_SC ? PSLVERR_SC : 1'b1;
          prdata_pm_d  = PREADY_SC ? PRDATA_SC : '0;
          psel_sc_d    = '0;
          paddr_sc_d   = '0;
          pwrite_sc_d  = 1'b0;
          penable_sc_d = 1'b0;
          pwdata_sc_d  = '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      psel_sc_q    <= '0;
      paddr_sc_q   <= '0;
      pwrite_sc_q  <= 1'b0;
      penable_sc_q <= 1'b0;
      pwdata_sc_q  <= '0;
      prdata_pm_q  <= '0;
      pready_pm_q  <= 1'b0;
      pslverr_pm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      psel_sc_q    <= psel_sc_d;
      paddr_sc_q   <= paddr_sc_d;
      pwrite_sc_q  <= pwrite_sc_d;
      penable_sc_q <= penable_sc_d;
      pwdata_sc_q  <= pwdata_sc_d;
      prdata_pm_q  <= prdata_pm_d;
      pready_pm_q  <= pready_pm_d;
      pslverr_pm_q <= pslverr_pm_d;
    end
  end

  assign PSEL_SC    = psel_sc_q;
  assign PADDR_SC   = paddr_sc_q;
  assign PWRITE_SC  = pwrite_sc_q;
  assign PENABLE_SC = penable_sc_q;
  assign PWDATA_SC  = pwdata_sc_q;
  assign PRDATA_PM  = prdata_pm_q;
  assign PREADY_PM  = pready_pm_q;
  assign PSLVERR_PM = pslverr_pm_q;

endmodule

// File: tb/tb_bfm_apb2apb_bridge.sv
// Self-checking bench for bfm_apb2apb_bridge: directed vector table, a reset
// sequence mid-access, and randomized transfers against a transaction-level model.
module tb_bfm_apb2apb_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int NSLV    = 6;
  localparam int SEL_LSB = 24;
  localparam int TIMEOUT = 8;
  localparam int BUDGET  = 40;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              PSEL_PM, PWRITE_PM, PENABLE_PM;
  logic [ADDR_W-1:0] PADDR_PM;
  logic [DATA_W-1:0] PWDATA_PM, PRDATA_PM;
  logic              PREADY_PM, PSLVERR_PM;
  logic [NSLV-1:0]   PSEL_SC;
  logic [ADDR_W-1:0] PADDR_SC;
  logic              PWRITE_SC, PENABLE_SC;
  logic [DATA_W-1:0] PWDATA_SC, PRDATA_SC;
  logic              PREADY_SC, PSLVERR_SC;

  always #5 PCLK = ~PCLK;

  bfm_apb2apb_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .PSEL_PM(PSEL_PM), .PADDR_PM(PADDR_PM), .PWRITE_PM(PWRITE_PM),
    .PENABLE_PM(PENABLE_PM), .PWDATA_PM(PWDATA_PM), .PRDATA_PM(PRDATA_PM),
    .PREADY_PM(PREADY_PM), .PSLVERR_PM(PSLVERR_PM),
    .PSEL_SC(PSEL_SC), .PADDR_SC(PADDR_SC), .PWRITE_SC(PWRITE_SC),
    .PENABLE_SC(PENABLE_SC), .PWDATA_SC(PWDATA_SC), .PRDATA_SC(PRDATA_SC),
    .PREADY_SC(PREADY_SC), .PSLVERR_SC(PSLVERR_SC)
  );

  typedef struct {
    logic [31:0]     addr;
    logic            write;
    logic [31:0]     wdata;
    int              waits;
    logic [31:0]     srdata;
    logic            serr;
    int              exp_lat;
    logic            exp_err;
    logic [31:0]     exp_rdata;
    logic [NSLV-1:0] exp_sel;
    int              exp_pen;
  } vec_t;

  typedef struct {
    int              lat;
    logic            err;
    logic [31:0]     rdata;
    logic [NSLV-1:0] sel;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic            write;
    int              pen;
    bit              onehot_ok;
    bit              clear_ok;
  } obs_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Transaction-level expectation: slot decode, wait count vs timeout budget.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   slot;
    r    = v;
    slot = int'((v.addr >> SEL_LSB) & 32'hF);
    if (slot >= NSLV) begin
      r.exp_lat = 1; r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_sel = '0; r.exp_pen = 0;
    end else begin
      r.exp_sel = NSLV'(1) << slot;
      if (v.waits < TIMEOUT) begin
        r.exp_lat = 3 + v.waits; r.exp_err = v.serr; r.exp_rdata = v.srdata;
        r.exp_pen = v.waits + 1;
      end else begin
        r.exp_lat = TIMEOUT + 2; r.exp_err = 1'b1; r.exp_rdata = '0; r.exp_pen = TIMEOUT;
      end
    end
    return r;
  endfunction

  // Acts as APB master on the PM side and as a slave with v.waits wait states on the SC side.
  task automatic run_txn(input vec_t v, output obs_t o);
    int acc;
    acc = 0;
    o = '{lat: -1, err: 1'b0, rdata: '0, sel: '0, addr: '0, wdata: '0, write: 1'b0,
          pen: 0, onehot_ok: 1'b1, clear_ok: 1'b0};
    @(posedge PCLK); #1;
    PSEL_PM = 1'b1; PENABLE_PM = 1'b0;
    PADDR_PM = v.addr; PWRITE_PM = v.write; PWDATA_PM = v.wdata;
    @(posedge PCLK); #1;
    PENABLE_PM = 1'b1;
    for (int k = 1; k <= BUDGET; k++) begin
      @(posedge PCLK); #1;
      if (!$onehot0(PSEL_SC)) o.onehot_ok = 1'b0;
      if (PSEL_SC != '0 && o.sel == '0) begin
        o.sel = PSEL_SC; o.addr = PADDR_SC; o.wdata = PWDATA_SC; o.write = PWRITE_SC;
      end
      if (PREADY_PM) begin
        o.lat = k; o.err = PSLVERR_PM; o.rdata = PRDATA_PM;
        o.clear_ok = (PSEL_SC == '0) && !PENABLE_SC && !PWRITE_SC &&
                     (PADDR_SC == '0) && (PWDATA_SC == '0);
        break;
      end
      if (PENABLE_SC) begin
        o.pen++;
        if (acc == v.waits) begin
          PREADY_SC = 1'b1; PRDATA_SC = v.srdata; PSLVERR_SC = v.serr;
        end else begin
          PREADY_SC = 1'b0; PRDATA_SC = $urandom; PSLVERR_SC = 1'($urandom_range(0, 1));
        end
        acc++;
      end else begin
        PREADY_SC = 1'b0; PRDATA_SC = $urandom; PSLVERR_SC = 1'($urandom_range(0, 1));
      end
    end
    PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PREADY_SC = 1'b0;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    obs_t o;
    bit   in_range;
    in_range = (v.exp_sel != '0);
    run_txn(v, o);
    check($sformatf("%s latency", tag), o.lat, v.exp_lat);
    check($sformatf("%s pslverr", tag), 32'(o.err), 32'(v.exp_err));
    check($sformatf("%s prdata", tag), o.rdata, v.exp_rdata);
    check($sformatf("%s psel_sc", tag), 32'(o.sel), 32'(v.exp_sel));
    check($sformatf("%s paddr_sc", tag), o.addr, in_range ? v.addr : 32'h0);
    check($sformatf("%s pwdata_sc", tag), o.wdata, in_range ? v.wdata : 32'h0);
    check($sformatf("%s pwrite_sc", tag), 32'(o.write), in_range ? 32'(v.write) : 32'h0);
    check($sformatf("%s penable cycles", tag), o.pen, v.exp_pen);
    check($sformatf("%s psel onehot", tag), 32'(o.onehot_ok), 32'h1);
    check($sformatf("%s slave cleared", tag), 32'(o.clear_ok), 32'h1);
    @(posedge PCLK); #1;
    check($sformatf("%s pready drop", tag), 32'(PREADY_PM), 32'h0);
    check($sformatf("%s pslverr drop", tag), 32'(PSLVERR_PM), 32'h0);
    check($sformatf("%s prdata hold", tag), PRDATA_PM, v.exp_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check($sformatf("%s psel_sc", tag), 32'(PSEL_SC), 32'h0);
    check($sformatf("%s penable_sc", tag), 32'(PENABLE_SC), 32'h0);
    check($sformatf("%s pwrite_sc", tag), 32'(PWRITE_SC), 32'h0);
    check($sformatf("%s paddr_sc", tag), PADDR_SC, 32'h0);
    check($sformatf("%s pwdata_sc", tag), PWDATA_SC, 32'h0);
    check($sformatf("%s pready_pm", tag), 32'(PREADY_PM), 32'h0);
    check($sformatf("%s pslverr_pm", tag), 32'(PSLVERR_PM), 32'h0);
    check($sformatf("%s prdata_pm", tag), PRDATA_PM, 32'h0);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    bit   saw_ready;

    // addr, write, wdata, waits, srdata, serr | lat, err, rdata, sel, penable cycles
    vecs[0] = '{32'h0300_0010, 1'b1, 32'hA5A5_5A5A, 0,   32'hDEAD_BEEF, 1'b0, 3,  1'b0, 32'hDEAD_BEEF, 6'h08, 1};
    vecs[1] = '{32'h0500_0044, 1'b0, 32'h0000_0000, 2,   32'h1234_5678, 1'b0, 5,  1'b0, 32'h1234_5678, 6'h20, 3};
    vecs[2] = '{32'h0700_0000, 1'b0, 32'h1111_2222, 0,   32'h5555_5555, 1'b0, 1,  1'b1, 32'h0000_0000, 6'h00, 0};
    vecs[3] = '{32'h0100_0000, 1'b0, 32'h0000_0000, 100, 32'h7777_7777, 1'b0, 10, 1'b1, 32'h0000_0000, 6'h02, 8};
    vecs[4] = '{32'h0200_0008, 1'b0, 32'h0000_0000, 7,   32'hCAFE_F00D, 1'b1, 10, 1'b1, 32'hCAFE_F00D, 6'h04, 8};
    vecs[5] = '{32'h0000_0004, 1'b1, 32'h0BAD_C0DE, 6,   32'h3C3C_3C3C, 1'b1, 9,  1'b1, 32'h3C3C_3C3C, 6'h01, 7};
    vecs[6] = '{32'h0F00_00FC, 1'b1, 32'h9999_9999, 0,   32'h4242_4242, 1'b0, 1,  1'b1, 32'h0000_0000, 6'h00, 0};

    PRESET = 1'b1; PSEL_PM = 1'b0; PENABLE_PM = 1'b0; PWRITE_PM = 1'b0;
    PADDR_PM = '0; PWDATA_PM = '0; PRDATA_SC = '0; PREADY_SC = 1'b0; PSLVERR_SC = 1'b0;
    repeat (2) @(posedge PCLK);
    #1;
    check_all_zero("reset");
    PRESET = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Reset in the middle of an ACCESS phase drops the transfer with no response.
    @(posedge PCLK); #1;
    PSEL_PM = 1'b1; PENABLE_PM = 1'b0; PADDR_PM = 32'h0200_0000; PWRITE_PM = 1'b1;
    PWDATA_PM = 32'hFEED_0001;
    @(posedge PCLK); #1;
    PENABLE_PM = 1'b1;
    repeat (3) @(posedge PCLK);
    #1;
    check("midrst penable before reset", 32'(PENABLE_SC), 32'h1);
    PRESET = 1'b1; PSEL_PM = 1'b0; PENABLE_PM = 1'b0;
    @(posedge PCLK); #1;
    check_all_zero("midrst");
    PRESET = 1'b0;
    saw_ready = 1'b0;
    repeat (12) begin
      @(posedge PCLK); #1;
      if (PREADY_PM || PENABLE_SC) saw_ready = 1'b1;
    end
    check("midrst no response", 32'(saw_ready), 32'h0);
    v = predict('{32'h0400_0020, 1'b0, 32'h0, 1, 32'h600D_DA7A, 1'b0, 0, 1'b0, 32'h0, '0, 0});
    apply_vec("postrst read", v);

    for (int i = 0; i < 20; i++) begin
      v.addr   = {4'($urandom), 4'($urandom_range(0, 7)), 24'($urandom)};
      v.write  = 1'($urandom_range(0, 1));
      v.wdata  = $urandom;
      v.waits  = $urandom_range(0, 10);
      v.srdata = $urandom;
      v.serr   = 1'($urandom_range(0, 1));
      apply_vec($sformatf("rnd%0d", i), predict(v));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
